// File: rtl/addsub_seq.sv
// addsub_seq: multi-cycle two's-complement adder/subtractor.
//   Processes WIDTH-bit operands CHUNK bits per clock through one shared
//   CHUNK-bit ripple slice. A start/busy/done handshake frames each operation.
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - synchronous active-low reset
//   start  - request a new operation (taken in IDLE or DONE only)
//   M      - mode: 0 = A+B, 1 = A-B
//   A, B   - WIDTH-bit operands, latched at the accepting edge
//   busy   - high while the operation is running
//   done   - one-cycle pulse when S and flags are updated
//   S      - WIDTH-bit result
//   Co     - carry out of MSB (in subtract, 1 = no borrow)
//   V      - signed overflow
//   Z      - result is zero
//   N      - result MSB
module addsub_seq #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             M,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Co,
    output logic             V,
    output logic             Z,
    output logic             N
);

    localparam int STEPS = WIDTH / CHUNK;
    localparam int IDXW  = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(STEPS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_r;
    logic [WIDTH-1:0]   op_a_r;
    logic [WIDTH-1:0]   op_b_r;
    logic [WIDTH-1:0]   acc_r;
    logic               carry_r;
    logic [IDXW-1:0]    idx_r;

    logic               busy_r;
    logic               done_r;
    logic [WIDTH-1:0]   s_r;
    logic               co_r;
    logic               v_r;
    logic               z_r;
    logic               n_r;

    logic [CHUNK:0]     chain_s;
    logic [CHUNK-1:0]   slice_sum_s;
    logic [WIDTH-1:0]   acc_next_s;
    logic               cin_msb_s;
    logic               cout_s;

    // All-zero detect on the full-width result.
    function automatic logic zero_flag(input logic [WIDTH-1:0] value);
        return (value == {WIDTH{1'b0}});
    endfunction

    // Shared CHUNK-bit ripple slice. The operand registers shift right each
    // RUN cycle, so the active chunk is always in the low bits.
    always_comb begin
        chain_s     = '0;
        slice_sum_s = '0;
        chain_s[0]  = carry_r;
        for (int i = 0; i < CHUNK; i++) begin
            slice_sum_s[i] = op_a_r[i] ^ op_b_r[i] ^ chain_s[i];
            chain_s[i+1]   = (op_a_r[i] & op_b_r[i]) |
                             (chain_s[i] & (op_a_r[i] ^ op_b_r[i]));
        end
    end

    // The partial result fills from the top down; after STEPS shifts the
    // first chunk has reached bit 0. chain_s[CHUNK-1] is the carry into the
    // MSB on the last step.
    assign acc_next_s = (acc_r >> CHUNK) | (WIDTH'(slice_sum_s) << (WIDTH - CHUNK));
    assign cin_msb_s  = chain_s[CHUNK-1];
    assign cout_s     = chain_s[CHUNK];

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            op_a_r  <= '0;
            op_b_r  <= '0;
            acc_r   <= '0;
            carry_r <= 1'b0;
            idx_r   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            s_r     <= '0;
            co_r    <= 1'b0;
            v_r     <= 1'b0;
            z_r     <= 1'b0;
            n_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        // Subtract is A + ~B + 1: invert B, seed carry with M.
                        op_a_r  <= A;
                        op_b_r  <= B ^ {WIDTH{M}};
                        carry_r <= M;
                        idx_r   <= '0;
                        busy_r  <= 1'b1;
                        state_r <= RUN;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    op_a_r  <= op_a_r >> CHUNK;
                    op_b_r  <= op_b_r >> CHUNK;
                    acc_r   <= acc_next_s;
                    carry_r <= cout_s;
                    idx_r   <= idx_r + {{(IDXW-1){1'b0}}, 1'b1};
                    if (idx_r == LAST_IDX) begin
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        s_r     <= acc_next_s;
                        co_r    <= cout_s;
                        v_r     <= cin_msb_s ^ cout_s;
                        z_r     <= zero_flag(acc_next_s);
                        n_r     <= acc_next_s[WIDTH-1];
                        state_r <= DONE;
                    end else begin
                        state_r <= RUN;
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        // Back-to-back: accept exactly as from IDLE.
                        op_a_r  <= A;
                        op_b_r  <= B ^ {WIDTH{M}};
                        carry_r <= M;
                        idx_r   <= '0;
                        busy_r  <= 1'b1;
                        state_r <= RUN;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign S    = s_r;
    assign Co   = co_r;
    assign V    = v_r;
    assign Z    = z_r;
    assign N    = n_r;

endmodule

// File: tb/tb_addsub_seq.sv
// tb_addsub_seq: directed vector table on the default configuration, plus
// handshake, back-to-back and reset sequences, and a reference-model sweep
// on WIDTH=16/CHUNK=4 and WIDTH=8/CHUNK=8 instances.
module tb_addsub_seq;

    logic clk;
    logic rst_n;

    // Default instance (WIDTH=8, CHUNK=2)
    logic       d_start, d_m, d_busy, d_done, d_co, d_v, d_z, d_n;
    logic [7:0] d_a, d_b, d_s;
    // WIDTH=16, CHUNK=4
    logic        w_start, w_m, w_busy, w_done, w_co, w_v, w_z, w_n;
    logic [15:0] w_a, w_b, w_s;
    // WIDTH=8, CHUNK=8
    logic       s_start, s_m, s_busy, s_done, s_co, s_v, s_z, s_n;
    logic [7:0] s_a, s_b, s_s;

    int checks;
    int errors;

    addsub_seq u_def (
        .clk(clk), .rst_n(rst_n), .start(d_start), .M(d_m), .A(d_a), .B(d_b),
        .busy(d_busy), .done(d_done), .S(d_s), .Co(d_co), .V(d_v), .Z(d_z), .N(d_n)
    );

    addsub_seq #(.WIDTH(16), .CHUNK(4)) u_w16 (
        .clk(clk), .rst_n(rst_n), .start(w_start), .M(w_m), .A(w_a), .B(w_b),
        .busy(w_busy), .done(w_done), .S(w_s), .Co(w_co), .V(w_v), .Z(w_z), .N(w_n)
    );

    addsub_seq #(.WIDTH(8), .CHUNK(8)) u_w8c8 (
        .clk(clk), .rst_n(rst_n), .start(s_start), .M(s_m), .A(s_a), .B(s_b),
        .busy(s_busy), .done(s_done), .S(s_s), .Co(s_co), .V(s_v), .Z(s_z), .N(s_n)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       m;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] s;
        logic       co;
        logic       v;
        logic       z;
        logic       n;
    } vec_t;

    vec_t vecs [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Start one operation on the default instance and wait for done.
    // Inputs are scrambled after the accepting edge to prove they are latched.
    task automatic run_def(input logic m, input logic [7:0] a, input logic [7:0] b,
                           output int lat, output int busy_cnt);
        d_m = m; d_a = a; d_b = b; d_start = 1'b1;
        tick();
        d_start = 1'b0;
        d_m = ~m; d_a = ~a; d_b = a ^ b;
        lat = 0;
        busy_cnt = 0;
        while (!d_done && lat < 20) begin
            if (d_busy) busy_cnt++;
            tick();
            lat++;
        end
    endtask

    // One random operation on a swept instance (0: 16/4, 1: 8/8) vs a model.
    task automatic sweep_op(input int which, input logic m,
                            input logic [15:0] a_in, input logic [15:0] b_in);
        int          w;
        int          steps;
        int          lat;
        logic [16:0] mask;
        logic [16:0] a, bb, full;
        logic [15:0] es;
        logic        eco, ev, ez, en;
        logic [15:0] gs;
        logic        gco, gv, gz, gn, cur_done;

        w     = (which == 0) ? 16 : 8;
        steps = (which == 0) ? 4 : 1;
        mask  = (17'd1 << w) - 17'd1;
        a     = {1'b0, a_in} & mask;
        bb    = (m ? ~{1'b0, b_in} : {1'b0, b_in}) & mask;
        full  = a + bb + {16'd0, m};
        es    = 16'(full & mask);
        eco   = full[w];
        ev    = (a[w-1] == bb[w-1]) && (es[w-1] != a[w-1]);
        ez    = (es == 16'd0);
        en    = es[w-1];

        if (which == 0) begin
            w_m = m; w_a = a_in; w_b = b_in; w_start = 1'b1;
        end else begin
            s_m = m; s_a = a_in[7:0]; s_b = b_in[7:0]; s_start = 1'b1;
        end
        tick();
        w_start = 1'b0; s_start = 1'b0;
        w_a = ~w_a; s_a = ~s_a;
        lat = 0;
        cur_done = (which == 0) ? w_done : s_done;
        while (!cur_done && lat < 20) begin
            tick();
            lat++;
            cur_done = (which == 0) ? w_done : s_done;
        end
        gs  = (which == 0) ? w_s  : {8'd0, s_s};
        gco = (which == 0) ? w_co : s_co;
        gv  = (which == 0) ? w_v  : s_v;
        gz  = (which == 0) ? w_z  : s_z;
        gn  = (which == 0) ? w_n  : s_n;
        check((which == 0) ? "w16_latency" : "c8_latency", lat, steps);
        check((which == 0) ? "w16_S" : "c8_S", {16'd0, gs}, {16'd0, es});
        check((which == 0) ? "w16_flags" : "c8_flags",
              {28'd0, gco, gv, gz, gn}, {28'd0, eco, ev, ez, en});
        tick();
    endtask

    // Main test sequence.
    initial begin
        int lat;
        int busy_cnt;
        int gap;
        int done_seen;

        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        d_start = 1'b0; d_m = 1'b0; d_a = 8'd0; d_b = 8'd0;
        w_start = 1'b0; w_m = 1'b0; w_a = 16'd0; w_b = 16'd0;
        s_start = 1'b0; s_m = 1'b0; s_a = 8'd0; s_b = 8'd0;

        //            m     a      b      S      Co    V     Z     N
        vecs[0] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[7] = '{1'b1, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1};

        tick();
        tick();
        check("reset_outputs", {19'd0, d_busy, d_done, d_s, d_co, d_v, d_z, d_n}, 32'd0);
        check("reset_w16", {15'd0, w_busy, w_done, w_s}, 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            run_def(vecs[i].m, vecs[i].a, vecs[i].b, lat, busy_cnt);
            check($sformatf("vec%0d_latency", i), lat, 4);
            check($sformatf("vec%0d_busy_cycles", i), busy_cnt, 4);
            check($sformatf("vec%0d_S", i), {24'd0, d_s}, {24'd0, vecs[i].s});
            check($sformatf("vec%0d_flags", i), {28'd0, d_co, d_v, d_z, d_n},
                  {28'd0, vecs[i].co, vecs[i].v, vecs[i].z, vecs[i].n});
            tick();
            check($sformatf("vec%0d_done_pulse", i), {31'd0, d_done}, 32'd0);
        end

        // start and new operands while busy are ignored
        d_m = 1'b0; d_a = 8'h10; d_b = 8'h20; d_start = 1'b1;
        tick();
        d_a = 8'hFF; d_b = 8'hFF; d_m = 1'b1; d_start = 1'b1;
        check("hs_busy", {31'd0, d_busy}, 32'd1);
        tick();
        tick();
        d_start = 1'b0;
        lat = 2;
        while (!d_done && lat < 20) begin
            tick();
            lat++;
        end
        check("hs_latency", lat, 4);
        check("hs_S", {24'd0, d_s}, 32'h30);
        tick();
        check("hs_idle_after", {30'd0, d_busy, d_done}, 32'd0);

        // back-to-back: start held in the DONE cycle
        run_def(1'b0, 8'h01, 8'h02, lat, busy_cnt);
        check("b2b_first_latency", lat, 4);
        check("b2b_first_S", {24'd0, d_s}, 32'h03);
        d_m = 1'b0; d_a = 8'h04; d_b = 8'h05; d_start = 1'b1;
        tick();
        d_start = 1'b0;
        check("b2b_no_gap", {30'd0, d_busy, d_done}, 32'd2);
        gap = 1;
        while (!d_done && gap < 20) begin
            tick();
            gap++;
        end
        check("b2b_done_spacing", gap, 5);
        check("b2b_second_S", {24'd0, d_s}, 32'h09);
        tick();

        // reset during the second RUN cycle
        d_m = 1'b0; d_a = 8'h7F; d_b = 8'h01; d_start = 1'b1;
        tick();
        d_start = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_outputs", {19'd0, d_busy, d_done, d_s, d_co, d_v, d_z, d_n}, 32'd0);
        done_seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (d_done || d_busy) done_seen++;
        end
        check("midrst_no_done", done_seen, 0);

        // parameter sweep against the reference model
        for (int i = 0; i < 20; i++) begin
            sweep_op(0, 1'($urandom_range(1, 0)), 16'($urandom), 16'($urandom));
            sweep_op(1, 1'($urandom_range(1, 0)), 16'($urandom), 16'($urandom));
        end
        // fixed corners on the swept instances
        sweep_op(0, 1'b0, 16'h7FFF, 16'h0001);
        sweep_op(0, 1'b1, 16'h1234, 16'h1234);
        sweep_op(1, 1'b1, 16'h0080, 16'h0001);
        sweep_op(1, 1'b0, 16'h00FF, 16'h0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
